// File: rtl/starfield_speed_ctrl.sv
// Starfield speed controller: ramps the starfield speed register toward a CPU target,
// one step every FRAMEDIV+1 vblank rising edges, with an immediate-override path.
module starfield_speed_ctrl #(
    parameter int DIV_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vblank,
    input  logic       cpu_wr,
    input  logic [1:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    output logic       sf_write,
    output logic [7:0] sf_data,
    output logic       busy
);

    typedef enum logic [1:0] {INIT, IDLE, WAIT, STEP} state_t;

    state_t             state_reg, state_next;
    logic [7:0]         target_reg, target_next;
    logic [7:0]         current_reg, current_next;
    logic [7:0]         step_reg, step_next;
    logic [DIV_W-1:0]   framediv_reg, framediv_next;
    logic [DIV_W-1:0]   fcnt_reg, fcnt_next;
    logic               vblank_q_reg;
    logic               sf_write_reg, sf_write_next;
    logic [7:0]         sf_data_reg, sf_data_next;
    logic               pend_reg, pend_next;

    logic       edge_det;
    logic       wr_target, wr_current, wr_step, wr_framediv;
    logic [8:0] step_eff, sum, diff;
    logic [7:0] step_val, target_after;

    assign edge_det    = vblank & ~vblank_q_reg;
    assign wr_target   = cpu_wr && (cpu_addr == 2'd0);
    assign wr_current  = cpu_wr && (cpu_addr == 2'd1);
    assign wr_step     = cpu_wr && (cpu_addr == 2'd2);
    assign wr_framediv = cpu_wr && (cpu_addr == 2'd3);

    assign busy     = (state_reg == WAIT) || (state_reg == STEP);
    assign sf_write = sf_write_reg;
    assign sf_data  = sf_data_reg;

    // Ramp arithmetic is 9-bit so overflow/underflow is visible before clamping to target.
    always_comb begin
        step_eff = (step_reg == 8'd0) ? 9'd1 : {1'b0, step_reg};
        sum      = {1'b0, current_reg} + step_eff;
        diff     = {1'b0, current_reg} - step_eff;
        if (target_reg > current_reg)
            step_val = (sum > {1'b0, target_reg}) ? target_reg : sum[7:0];
        else
            step_val = (diff[8] || (diff[7:0] < target_reg)) ? target_reg : diff[7:0];
    end

    always_comb begin
        case (cpu_addr)
            2'd0:    cpu_dout = target_reg;
            2'd1:    cpu_dout = current_reg;
            2'd2:    cpu_dout = step_reg;
            default: cpu_dout = {busy, {(7-DIV_W){1'b0}}, framediv_reg};
        endcase
    end

    always_comb begin
        state_next    = state_reg;
        target_next   = target_reg;
        current_next  = current_reg;
        step_next     = step_reg;
        framediv_next = framediv_reg;
        fcnt_next     = fcnt_reg;
        sf_write_next = 1'b0;
        sf_data_next  = sf_data_reg;
        pend_next     = pend_reg;
        target_after  = wr_target ? cpu_din : target_reg;

        if (wr_step)
            step_next = cpu_din;
        if (wr_framediv)
            framediv_next = cpu_din[DIV_W-1:0];

        case (state_reg)
            INIT: begin
                sf_write_next = 1'b1;
                sf_data_next  = 8'd0;
                state_next    = IDLE;
                if (wr_target) begin
                    target_next = cpu_din;
                    if (cpu_din != 8'd0) begin
                        fcnt_next  = '0;
                        state_next = WAIT;
                    end
                end
                // A CURRENT write here is replayed as a pulse right after the INIT pulse.
                if (wr_current) begin
                    current_next = cpu_din;
                    target_next  = cpu_din;
                    pend_next    = 1'b1;
                end
            end
            IDLE: begin
                if (pend_reg) begin
                    sf_write_next = 1'b1;
                    sf_data_next  = current_reg;
                    pend_next     = 1'b0;
                end
                if (wr_target) begin
                    target_next = cpu_din;
                    if (cpu_din != current_reg) begin
                        fcnt_next  = '0;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (edge_det) begin
                    if (fcnt_reg >= framediv_reg) begin
                        fcnt_next  = '0;
                        state_next = STEP;
                    end else begin
                        fcnt_next = fcnt_reg + DIV_W'(1);
                    end
                end
                if (wr_target) begin
                    target_next = cpu_din;
                    if (cpu_din == current_reg)
                        state_next = IDLE;
                end
            end
            default: begin
                sf_write_next = 1'b1;
                sf_data_next  = step_val;
                current_next  = step_val;
                target_next   = target_after;
                state_next    = (step_val == target_after) ? IDLE : WAIT;
            end
        endcase

        // CPU override wins over everything, including a concurrent ramp step.
        if (wr_current && (state_reg != INIT)) begin
            current_next  = cpu_din;
            target_next   = cpu_din;
            fcnt_next     = '0;
            state_next    = IDLE;
            sf_write_next = 1'b1;
            sf_data_next  = cpu_din;
            pend_next     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= INIT;
            target_reg   <= 8'd0;
            current_reg  <= 8'd0;
            step_reg     <= 8'd1;
            framediv_reg <= '0;
            fcnt_reg     <= '0;
            vblank_q_reg <= 1'b0;
            sf_write_reg <= 1'b0;
            sf_data_reg  <= 8'd0;
            pend_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            target_reg   <= target_next;
            current_reg  <= current_next;
            step_reg     <= step_next;
            framediv_reg <= framediv_next;
            fcnt_reg     <= fcnt_next;
            vblank_q_reg <= vblank;
            sf_write_reg <= sf_write_next;
            sf_data_reg  <= sf_data_next;
            pend_reg     <= pend_next;
        end
    end

endmodule

// File: tb/tb_starfield_speed_ctrl.sv
// Self-checking bench for starfield_speed_ctrl: expected starfield writes (value and
// cycle) are queued when stimulus is driven and matched as sf_write pulses appear.
module tb_starfield_speed_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vblank;
    logic       cpu_wr;
    logic [1:0] cpu_addr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       sf_write;
    logic [7:0] sf_data;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0]      start;
        logic [7:0]      step;
        logic [4:0]      fdiv;
        logic [7:0]      target;
        int              pulses;
        logic [15:0]     mask;
        logic [3:0][7:0] vals;
    } ramp_t;
    ramp_t tbl[5];

    starfield_speed_ctrl #(.DIV_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vblank   (vblank),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .sf_write (sf_write),
        .sf_data  (sf_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every sf_write pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (sf_write) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got data=%0d at cycle %0d, required no write", sf_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (sf_data !== e.data || cyc != e.cyc)
                    begin
                        errors++;
                        $display("FAIL sf_write: got data=%0d at cycle %0d, required data=%0d at cycle %0d",
                                 sf_data, cyc, e.data, e.cyc);
                    end
                $display("write: data=%0d cycle=%0d (expected %0d @ %0d)", sf_data, cyc, e.data, e.cyc);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic read_chk(input string name, input logic [1:0] a, input logic [7:0] req);
        cpu_addr = a;
        #1;
        chk(name, {24'd0, cpu_dout}, {24'd0, req});
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_wr   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
        if (a == 2'd1)
            exp_q.push_back('{d, cyc + 1});
        @(negedge clk);
        cpu_wr = 1'b0;
    endtask

    task automatic vb_pulse(input bit expect_wr, input logic [7:0] v);
        @(negedge clk);
        vblank = 1'b1;
        if (expect_wr)
            exp_q.push_back('{v, cyc + 2});
        repeat (2) @(negedge clk);
        vblank = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic q_empty(input string name);
        repeat (3) @(negedge clk);
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        tbl[0] = '{8'd0,   8'd10,  5'd0, 8'd35,  5,  16'h000F, {8'd35, 8'd30, 8'd20, 8'd10}};
        tbl[1] = '{8'd0,   8'd1,   5'd2, 8'd3,   10, 16'h0124, {8'd0,  8'd3,  8'd2,  8'd1}};
        tbl[2] = '{8'd5,   8'd200, 5'd0, 8'd0,   2,  16'h0001, {8'd0,  8'd0,  8'd0,  8'd0}};
        tbl[3] = '{8'd250, 8'd10,  5'd0, 8'd255, 2,  16'h0001, {8'd0,  8'd0,  8'd0,  8'd255}};
        tbl[4] = '{8'd7,   8'd0,   5'd0, 8'd9,   3,  16'h0003, {8'd0,  8'd0,  8'd9,  8'd8}};

        rst_n = 1'b0; vblank = 1'b0; cpu_wr = 1'b0; cpu_addr = 2'd0; cpu_din = 8'd0;

        // Reset release: a single INIT write of 0 one cycle later.
        repeat (3) @(negedge clk);
        chk("reset_sf_write", {31'd0, sf_write}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        exp_q.push_back('{8'd0, cyc + 1});
        @(negedge clk);
        chk("init_busy", {31'd0, busy}, 0);
        read_chk("init_step", 2'd2, 8'd1);
        read_chk("init_target", 2'd0, 8'd0);
        read_chk("init_fdiv", 2'd3, 8'd0);
        q_empty("init_pending");

        // Table-driven ramps.
        for (int r = 0; r < 5; r++) begin
            int vi;
            vi = 0;
            cpu_write(2'd1, tbl[r].start);
            cpu_write(2'd2, tbl[r].step);
            cpu_write(2'd3, {3'd0, tbl[r].fdiv});
            cpu_write(2'd0, tbl[r].target);
            @(negedge clk);
            chk("ramp_busy_hi", {31'd0, busy}, 1);
            read_chk("ramp_fdiv_rd", 2'd3, {1'b1, 2'b00, tbl[r].fdiv});
            for (int p = 0; p < tbl[r].pulses; p++) begin
                if (tbl[r].mask[p]) begin
                    vb_pulse(1'b1, tbl[r].vals[vi]);
                    vi++;
                end else begin
                    vb_pulse(1'b0, 8'd0);
                end
            end
            q_empty("ramp_pending");
            chk("ramp_busy_lo", {31'd0, busy}, 0);
            read_chk("ramp_current", 2'd1, tbl[r].target);
            read_chk("ramp_step_raw", 2'd2, tbl[r].step);
            $display("ramp %0d: start=%0d step=%0d fdiv=%0d target=%0d done", r,
                     tbl[r].start, tbl[r].step, tbl[r].fdiv, tbl[r].target);
        end

        // CURRENT write landing in the STEP cycle overrides the ramp value.
        cpu_write(2'd1, 8'd0);
        cpu_write(2'd2, 8'd5);
        cpu_write(2'd3, 8'd0);
        cpu_write(2'd0, 8'd100);
        @(negedge clk);
        vblank = 1'b1;
        @(negedge clk);
        chk("step_busy", {31'd0, busy}, 1);
        cpu_wr = 1'b1; cpu_addr = 2'd1; cpu_din = 8'h80;
        exp_q.push_back('{8'h80, cyc + 1});
        @(negedge clk);
        cpu_wr = 1'b0;
        @(negedge clk);
        vblank = 1'b0;
        chk("override_busy", {31'd0, busy}, 0);
        read_chk("override_target", 2'd0, 8'h80);
        read_chk("override_current", 2'd1, 8'h80);
        vb_pulse(1'b0, 8'd0);
        vb_pulse(1'b0, 8'd0);
        q_empty("override_pending");

        // TARGET rewritten to the current value during WAIT ends the ramp silently.
        cpu_write(2'd1, 8'd0);
        cpu_write(2'd2, 8'd10);
        cpu_write(2'd0, 8'd50);
        vb_pulse(1'b1, 8'd10);
        cpu_write(2'd0, 8'd10);
        @(negedge clk);
        chk("retarget_busy", {31'd0, busy}, 0);
        vb_pulse(1'b0, 8'd0);
        vb_pulse(1'b0, 8'd0);
        q_empty("retarget_pending");

        // Asynchronous reset while waiting between vblanks.
        cpu_write(2'd1, 8'd0);
        cpu_write(2'd3, 8'd3);
        cpu_write(2'd0, 8'd100);
        vb_pulse(1'b0, 8'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sf_write", {31'd0, sf_write}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        read_chk("arst_target", 2'd0, 8'd0);
        read_chk("arst_step", 2'd2, 8'd1);
        read_chk("arst_fdiv", 2'd3, 8'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{8'd0, cyc + 1});
        vb_pulse(1'b0, 8'd0);
        vb_pulse(1'b0, 8'd0);
        q_empty("arst_pending");
        read_chk("arst_current", 2'd1, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
